// File: rtl/command_credit_queue.sv
// Credit-gated command FIFO between a work element and the PSL command interface.
// Optional feature: define CREDIT_CHECK_EN to enable the sticky credit_error check.
module command_credit_queue #(
  parameter int DEPTH    = 8,
  parameter int CREDIT_W = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enabled,
  input  logic [CREDIT_W-1:0]       croom,
  input  logic                      in_valid,
  input  logic [12:0]               in_command,
  input  logic [7:0]                in_tag,
  input  logic [63:0]               in_address,
  input  logic [11:0]               in_size,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [12:0]               out_command,
  output logic [7:0]                out_tag,
  output logic [63:0]               out_address,
  output logic [11:0]               out_size,
  output logic                      out_command_parity,
  output logic                      out_tag_parity,
  output logic                      out_address_parity,
  input  logic                      response_valid,
  input  logic [8:0]                response_credits,
  output logic [CREDIT_W-1:0]       credits,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic                      credit_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = ((CREDIT_W > 9) ? CREDIT_W : 9) + 2;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic signed [SW-1:0] CREDIT_MAX = SW'((1 << CREDIT_W) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  typedef struct packed {
    logic [12:0] command;
    logic [7:0]  tag;
    logic [63:0] address;
    logic [11:0] size;
  } cmd_t;

  state_t            state;
  cmd_t              mem [DEPTH];
  cmd_t              in_cmd;
  cmd_t              head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic signed [SW-1:0] held_s;
  logic signed [SW-1:0] issue_s;
  logic signed [SW-1:0] resp_s;
  logic signed [SW-1:0] credit_sum;
  logic [CREDIT_W-1:0]  credit_next;

  assign in_cmd    = '{command: in_command, tag: in_tag, address: in_address, size: in_size};
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  // Issue is gated by enabled too, so nothing pops on the edge that leaves RUN.
  assign can_issue = (state == RUN) && enabled && (credits != '0);
  // An empty FIFO forwards the incoming command on the push edge for one-cycle latency.
  assign pop       = can_issue && (!empty || push);
  assign head      = empty ? in_cmd : mem[rd_ptr];

  always_comb begin
    held_s     = {{(SW-CREDIT_W){1'b0}}, credits};
    issue_s    = {{(SW-1){1'b0}}, pop};
    resp_s     = '0;
    if (response_valid) resp_s = {{(SW-9){response_credits[8]}}, response_credits};
    credit_sum = held_s - issue_s + resp_s;
    if (credit_sum[SW-1])            credit_next = '0;
    else if (credit_sum > CREDIT_MAX) credit_next = '1;
    else                             credit_next = credit_sum[CREDIT_W-1:0];
  end

  // NOTE: storage has no reset; validity is tracked by count/pointers, which are reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      credits     <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      out_command <= '0;
      out_tag     <= '0;
      out_address <= '0;
      out_size    <= '0;
    end else begin
      case (state)
        IDLE:    if (enabled) state <= LOAD;
        LOAD:    state <= RUN;
        RUN:     if (!enabled) state <= HALT;
        HALT:    if (enabled) state <= RUN;
        default: state <= IDLE;
      endcase

      credits <= (state == LOAD) ? croom : credit_next;

      if (in_valid && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      out_valid <= pop;
      if (pop) begin
        out_command <= head.command;
        out_tag     <= head.tag;
        out_address <= head.address;
        out_size    <= head.size;
      end
    end
  end

`ifdef CREDIT_CHECK_EN
  logic [CREDIT_W-1:0]  loaded_croom;
  logic signed [SW-1:0] loaded_s;

  assign loaded_s = {{(SW-CREDIT_W){1'b0}}, loaded_croom};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      loaded_croom <= '0;
      credit_error <= 1'b0;
    end else if (state == LOAD) begin
      loaded_croom <= croom;
    end else if (credit_sum[SW-1] || (credit_sum > loaded_s)) begin
      credit_error <= 1'b1;
    end
  end
`else
  assign credit_error = 1'b0;
`endif

  assign fifo_count         = count;
  assign out_command_parity = ~^out_command;
  assign out_tag_parity     = ~^out_tag;
  assign out_address_parity = ~^out_address;

endmodule

// File: tb/tb_command_credit_queue.sv
// Randomised scoreboard bench for command_credit_queue against a queue-based reference model.
module tb_command_credit_queue;
  localparam int DEPTH    = 8;
  localparam int CREDIT_W = 8;
  localparam int CMAX     = (1 << CREDIT_W) - 1;

  logic                   clock;
  logic                   reset_n;
  logic                   enabled;
  logic [CREDIT_W-1:0]    croom;
  logic                   in_valid;
  logic [12:0]            in_command;
  logic [7:0]             in_tag;
  logic [63:0]            in_address;
  logic [11:0]            in_size;
  logic                   in_ready;
  logic                   out_valid;
  logic [12:0]            out_command;
  logic [7:0]             out_tag;
  logic [63:0]            out_address;
  logic [11:0]            out_size;
  logic                   out_command_parity;
  logic                   out_tag_parity;
  logic                   out_address_parity;
  logic                   response_valid;
  logic [8:0]             response_credits;
  logic [CREDIT_W-1:0]    credits;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   credit_error;

  command_credit_queue #(.DEPTH(DEPTH), .CREDIT_W(CREDIT_W)) dut (
    .clock(clock), .reset_n(reset_n), .enabled(enabled), .croom(croom),
    .in_valid(in_valid), .in_command(in_command), .in_tag(in_tag),
    .in_address(in_address), .in_size(in_size), .in_ready(in_ready),
    .out_valid(out_valid), .out_command(out_command), .out_tag(out_tag),
    .out_address(out_address), .out_size(out_size),
    .out_command_parity(out_command_parity), .out_tag_parity(out_tag_parity),
    .out_address_parity(out_address_parity),
    .response_valid(response_valid), .response_credits(response_credits),
    .credits(credits), .fifo_count(fifo_count), .overflow(overflow),
    .credit_error(credit_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [12:0] command;
    logic [7:0]  tag;
    logic [63:0] address;
    logic [11:0] size;
  } cmd_t;

  typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mode_t;

  cmd_t  m_q[$];
  cmd_t  sb_q[$];
  mode_t m_mode;
  int    m_credits;
  int    m_loaded;
  bit    m_overflow;
  bit    m_err;
  bit    m_valid;
  bit    mon_en;
  int    checks;
  int    failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edge the DUT samples its inputs.
  task automatic cycle();
    cmd_t c;
    bit   issued;
    int   sum;
    int   r;
    @(posedge clock);
    if (!reset_n) begin
      m_q.delete();
      m_mode = M_IDLE; m_credits = 0; m_loaded = 0;
      m_overflow = 0; m_err = 0; m_valid = 0;
    end else begin
      issued = 0;
      if (in_valid) begin
        if (m_q.size() == DEPTH) m_overflow = 1;
        else begin
          c.command = in_command; c.tag = in_tag; c.address = in_address; c.size = in_size;
          m_q.push_back(c);
        end
      end
      if (m_mode == M_RUN && enabled && m_credits > 0 && m_q.size() > 0) begin
        sb_q.push_back(m_q.pop_front());
        issued = 1;
      end
      if (m_mode == M_LOAD) begin
        m_credits = croom;
        m_loaded  = croom;
      end else begin
        r = 0;
        if (response_valid) r = $signed(response_credits);
        sum = m_credits - int'(issued) + r;
`ifdef CREDIT_CHECK_EN
        if (sum < 0 || sum > m_loaded) m_err = 1;
`endif
        m_credits = (sum < 0) ? 0 : (sum > CMAX) ? CMAX : sum;
      end
      case (m_mode)
        M_IDLE: if (enabled) m_mode = M_LOAD;
        M_LOAD: m_mode = M_RUN;
        M_RUN:  if (!enabled) m_mode = M_HALT;
        M_HALT: if (enabled) m_mode = M_RUN;
        default: m_mode = M_IDLE;
      endcase
      m_valid = issued;
    end
    #1;
  endtask

  always @(negedge clock) begin
    cmd_t e;
    if (mon_en) begin
      check("out_valid", out_valid, m_valid);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("out_command", out_command, e.command);
          check("out_tag", out_tag, e.tag);
          check("out_address", out_address, e.address);
          check("out_size", out_size, e.size);
          check("cmd_parity", out_command_parity, ~^e.command);
          check("tag_parity", out_tag_parity, ~^e.tag);
          check("addr_parity", out_address_parity, ~^e.address);
        end
      end
      check("credits", credits, m_credits);
      check("fifo_count", fifo_count, m_q.size());
      check("in_ready", in_ready, m_q.size() != DEPTH);
      check("overflow", overflow, m_overflow);
      check("credit_error", credit_error, m_err);
    end
  end

  task automatic idle(input int n);
    in_valid = 0; response_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [12:0] cmd, input logic [7:0] tag,
                      input logic [63:0] addr, input logic [11:0] size);
    in_valid = 1; in_command = cmd; in_tag = tag; in_address = addr; in_size = size;
    cycle();
    in_valid = 0;
  endtask

  task automatic push_rand();
    push(13'($urandom), 8'($urandom), {$urandom, $urandom}, 12'($urandom));
  endtask

  task automatic respond(input int n);
    response_valid = 1; response_credits = 9'(n);
    cycle();
    response_valid = 0;
  endtask

  task automatic restart(input int room);
    reset_n = 0; enabled = 0; in_valid = 0; response_valid = 0;
    cycle(); cycle();
    reset_n = 1; croom = CREDIT_W'(room); enabled = 1;
    cycle(); cycle();
  endtask

  initial begin
    checks = 0; failures = 0; mon_en = 0;
    reset_n = 0; enabled = 0; croom = '0; in_valid = 0; in_command = '0; in_tag = '0;
    in_address = '0; in_size = '0; response_valid = 0; response_credits = '0;
    cycle();
    mon_en = 1;
    cycle();
    check("rst_out_command", out_command, 0);
    check("rst_out_address", out_address, 0);
    check("rst_parity", {out_command_parity, out_tag_parity, out_address_parity}, 3'b111);

    // Basic single command with croom=4.
    reset_n = 1; croom = 8'd4; enabled = 1;
    cycle(); cycle();
    push(13'h0A00, 8'd1, 64'h1000, 12'd128);
    check("basic_credits", credits, 3);
    idle(2);

    // Starvation with a single credit.
    restart(1);
    push_rand(); push_rand(); push_rand();
    idle(3);
    check("starve_count", fifo_count, 2);
    respond(1);
    idle(3);
    check("starve_after", fifo_count, 1);

    // Fill with no credits, overflow on the ninth push, then drain.
    restart(0);
    for (int i = 0; i < 9; i++) push_rand();
    check("full_ready", in_ready, 0);
    check("full_overflow", overflow, 1);
    check("full_count", fifo_count, 8);
    respond(8);
    idle(10);

    // Issue and +2 response on the same edge.
    restart(1);
    in_valid = 1; in_command = 13'h0D00; in_tag = 8'd7; in_address = 64'h2000; in_size = 12'd64;
    response_valid = 1; response_credits = 9'd2;
    cycle();
    in_valid = 0; response_valid = 0;
    check("simul_credits", credits, 2);
    idle(2);

    // Halt keeps the queue, resume drains, reset mid-drain empties it.
    restart(8);
    enabled = 0; cycle();
    push_rand(); push_rand(); push_rand();
    idle(3);
    check("halt_count", fifo_count, 3);
    enabled = 1; cycle(); cycle(); cycle();
    reset_n = 0; cycle();
    check("midreset_count", fifo_count, 0);
    reset_n = 1; enabled = 0; idle(2);

    // Clamp at both ends; also over-return beyond croom.
    restart(4);
    respond(5);
    respond(255);
    check("clamp_high", credits, CMAX);
    respond(-256);
    check("clamp_low", credits, 0);

    // Randomised traffic.
    for (int round = 0; round < 20; round++) begin
      restart($urandom_range(0, 12));
      for (int n = 0; n < 150; n++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_command = 13'($urandom); in_tag = 8'($urandom);
        in_address = {$urandom, $urandom}; in_size = 12'($urandom);
        response_valid = ($urandom_range(0, 4) == 0);
        response_credits = 9'($urandom_range(0, 4) - 1);
        if ($urandom_range(0, 19) == 0) enabled = !enabled;
        reset_n = ($urandom_range(0, 199) != 0);
        cycle();
      end
      reset_n = 1; enabled = 1;
      idle(2);
    end

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
